// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared state encoding, flash command constants and nibble helpers for qspi_mc
package qspi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_GAP
   } qspi_state_t;

   localparam logic [7:0] CMD_READ  = 8'hEB;
   localparam logic [7:0] CMD_WRITE = 8'h38;
   localparam int         ADDR_W    = 24;

   function automatic logic [3:0] cmd_nibble(input logic [7:0] cmd, input logic lo);
      return lo ? cmd[3:0] : cmd[7:4];
   endfunction

   // Address goes out most significant nibble first.
   function automatic logic [3:0] addr_nibble(input logic [ADDR_W-1:0] a, input logic [2:0] idx);
      case (idx)
         3'd0:    return a[23:20];
         3'd1:    return a[19:16];
         3'd2:    return a[15:12];
         3'd3:    return a[11:8];
         3'd4:    return a[7:4];
         3'd5:    return a[3:0];
         default: return 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/qspi_arb.sv
// rtl/qspi_arb.sv - two-requester fair arbiter; the requester not granted last wins a tie
module qspi_arb (
   input  logic clk,
   input  logic reset,
   input  logic i_ireq,
   input  logic i_dreq,
   input  logic i_take,
   output logic o_valid,
   output logic o_gnt_d
);

   logic r_last_i;

   assign o_valid = i_ireq | i_dreq;
   assign o_gnt_d = i_dreq & (~i_ireq | r_last_i);

   // Reset leaves the icache as last winner so the dcache takes the first tie.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_last_i <= 1'b1;
      end else if (i_take && o_valid) begin
         r_last_i <= ~o_gnt_d;
      end
   end

endmodule

// File: rtl/qspi_mc.sv
// rtl/qspi_mc.sv - quad-SPI line-fill/write-back controller for icache and dcache
// Optional runtime command/dummy registers enabled by defining QSPI_MC_CFG_EN.
module qspi_mc
   import qspi_pkg::*;
#(
   parameter  int PA          = 22,
   parameter  int LINE_LENGTH = 4,
   parameter  int NCS         = 2,
   parameter  int DUMMY       = 4,
   localparam int LW          = $clog2(LINE_LENGTH),
   localparam int TW          = PA - LW,
   localparam int CSW         = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [TW-1:0]   i_tag,
   input  logic [CSW-1:0]  i_cs,
   output logic            i_wstrobe,
   output logic            i_ack,
   input  logic            d_req,
   input  logic            d_write,
   input  logic [TW-1:0]   d_tag,
   input  logic [CSW-1:0]  d_cs,
   output logic            d_wstrobe,
   output logic            d_rstrobe,
   output logic            d_ack,
   input  logic [3:0]      dwrite,
   input  logic [3:0]      qdin,
   output logic [3:0]      qdout,
   output logic [3:0]      qoe,
   output logic [NCS-1:0]  cs,
   output logic [3:0]      dread
`ifdef QSPI_MC_CFG_EN
   ,
   input  logic            cfg_write,
   input  logic [1:0]      cfg_addr,
   input  logic [7:0]      cfg_data
`endif
);

   localparam int CNTW  = 4 + LW;
   localparam int NDATA = 2 * LINE_LENGTH;

   qspi_state_t       r_state, w_next;
   logic [CNTW-1:0]   r_cnt, w_cnt_inc, w_cnt_next;
   logic              r_gnt_d, r_write, r_rd_stb;
   logic [CSW-1:0]    r_cs;
   logic [ADDR_W-1:0] r_addr, w_addr24;
   logic [7:0]        r_cmd;
   logic [3:0]        r_dummy, r_dread;
   logic              w_valid, w_gnt_d, w_take, w_busy;
   logic [3:0]        w_qdout, w_qoe;
   logic [TW-1:0]     w_tag;
   logic [PA-1:0]     w_line_addr;
   logic [3:0]        w_cfg_dummy;
   logic [7:0]        w_cfg_rd, w_cfg_wr;

`ifdef QSPI_MC_CFG_EN
   logic [3:0] r_cfg_dummy;
   logic [7:0] r_cfg_rd, r_cfg_wr;

   // Only IDLE writes land; the values are copied into the transfer at the next grant.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cfg_dummy <= 4'(DUMMY);
         r_cfg_rd    <= CMD_READ;
         r_cfg_wr    <= CMD_WRITE;
      end else if (cfg_write && r_state == ST_IDLE) begin
         case (cfg_addr)
            2'd0:    r_cfg_dummy <= cfg_data[3:0];
            2'd1:    r_cfg_rd    <= cfg_data;
            2'd2:    r_cfg_wr    <= cfg_data;
            default: ;
         endcase
      end
   end

   assign w_cfg_dummy = r_cfg_dummy;
   assign w_cfg_rd    = r_cfg_rd;
   assign w_cfg_wr    = r_cfg_wr;
`else
   assign w_cfg_dummy = 4'(DUMMY);
   assign w_cfg_rd    = CMD_READ;
   assign w_cfg_wr    = CMD_WRITE;
`endif

   assign w_take = (r_state == ST_IDLE);

   qspi_arb u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_ireq  (i_req),
      .i_dreq  (d_req),
      .i_take  (w_take),
      .o_valid (w_valid),
      .o_gnt_d (w_gnt_d)
   );

   assign w_tag       = w_gnt_d ? d_tag : i_tag;
   assign w_line_addr = {w_tag, {LW{1'b0}}};

   generate
      if (PA >= ADDR_W) begin : g_addr_trunc
         assign w_addr24 = w_line_addr[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign w_addr24 = {{(ADDR_W-PA){1'b0}}, w_line_addr};
      end
   endgenerate

   assign w_cnt_inc = r_cnt + CNTW'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_gnt_d  <= 1'b0;
         r_write  <= 1'b0;
         r_cs     <= '0;
         r_addr   <= '0;
         r_cmd    <= '0;
         r_dummy  <= '0;
         r_rd_stb <= 1'b0;
         r_dread  <= '0;
      end else begin
         r_state  <= w_next;
         r_cnt    <= w_cnt_next;
         if (r_state == ST_IDLE && w_valid) begin
            r_gnt_d <= w_gnt_d;
            r_write <= w_gnt_d & d_write;
            r_cs    <= w_gnt_d ? d_cs : i_cs;
            r_addr  <= w_addr24;
            r_cmd   <= (w_gnt_d && d_write) ? w_cfg_wr : w_cfg_rd;
            r_dummy <= w_cfg_dummy;
         end
         r_rd_stb <= (r_state == ST_DATA) && !r_write;
         if (r_state == ST_DATA && !r_write) begin
            r_dread <= qdin;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = w_cnt_inc;
      w_qdout    = 4'h0;
      w_qoe      = 4'h0;
      w_busy     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_next = '0;
            if (w_valid) w_next = ST_CMD;
         end
         ST_CMD: begin
            w_busy  = 1'b1;
            w_qoe   = 4'hF;
            w_qdout = cmd_nibble(r_cmd, r_cnt[0]);
            if (r_cnt[0]) begin
               w_cnt_next = '0;
               w_next     = ST_ADDR;
            end
         end
         ST_ADDR: begin
            w_busy  = 1'b1;
            w_qoe   = 4'hF;
            w_qdout = addr_nibble(r_addr, r_cnt[2:0]);
            if (w_cnt_inc == CNTW'(6)) begin
               w_cnt_next = '0;
               w_next     = (r_write || r_dummy == 4'd0) ? ST_DATA : ST_DUMMY;
            end
         end
         ST_DUMMY: begin
            w_busy = 1'b1;
            if (w_cnt_inc == CNTW'(r_dummy)) begin
               w_cnt_next = '0;
               w_next     = ST_DATA;
            end
         end
         ST_DATA: begin
            w_busy = 1'b1;
            if (r_write) begin
               w_qoe   = 4'hF;
               w_qdout = dwrite;
            end
            if (w_cnt_inc == CNTW'(NDATA)) begin
               w_cnt_next = '0;
               w_next     = ST_GAP;
            end
         end
         ST_GAP: begin
            w_cnt_next = '0;
            w_next     = ST_IDLE;
         end
         default: begin
            w_cnt_next = '0;
            w_next     = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      for (int k = 0; k < NCS; k++) begin
         cs[k] = ~(w_busy && r_cs == CSW'(k));
      end
   end

   assign qdout     = w_qdout;
   assign qoe       = w_qoe;
   assign dread     = r_dread;
   assign i_wstrobe = r_rd_stb & ~r_gnt_d;
   assign d_wstrobe = r_rd_stb & r_gnt_d;
   assign d_rstrobe = (r_state == ST_DATA) && r_write;
   assign i_ack     = (r_state == ST_GAP) && !r_gnt_d;
   assign d_ack     = (r_state == ST_GAP) && r_gnt_d;

endmodule

// File: tb/tb_qspi_mc.sv
// tb/tb_qspi_mc.sv - scoreboard bench for qspi_mc; covers QSPI_MC_CFG_EN when defined
module tb_qspi_mc;

   typedef struct {
      int who;
      int cyc;
   } ack_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_write = 1'b0;
   logic [19:0] i_tag = '0, d_tag = '0;
   logic        i_cs = 1'b0, d_cs = 1'b0;
   logic        i_wstrobe, i_ack, d_wstrobe, d_rstrobe, d_ack;
   logic [3:0]  dwrite = 4'h0, qdin = 4'h0;
   logic [3:0]  qdout, qoe, dread;
   logic [1:0]  cs;
`ifdef QSPI_MC_CFG_EN
   logic        cfg_write = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [7:0]  cfg_data = 8'h00;
`endif

   logic [3:0]  exp_q[$];
   logic [3:0]  exp_i[$];
   logic [3:0]  exp_d[$];
   logic [1:0]  exp_cs[$];
   ack_t        exp_ack[$];
   logic [3:0]  qdin_map[int];

   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          rs_cnt = 0, w_base = 0, n_fall = 0, gap_idx = -1, last_low = 0;
   logic [31:0] w_line = '0;
   logic        prev_low = 1'b0;
   logic [1:0]  cur_cs = 2'b11;
   ack_t        a_pop;
   int          widx;

   qspi_mc #(.PA(22), .LINE_LENGTH(4), .NCS(2), .DUMMY(4)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .i_req     (i_req),
      .i_tag     (i_tag),
      .i_cs      (i_cs),
      .i_wstrobe (i_wstrobe),
      .i_ack     (i_ack),
      .d_req     (d_req),
      .d_write   (d_write),
      .d_tag     (d_tag),
      .d_cs      (d_cs),
      .d_wstrobe (d_wstrobe),
      .d_rstrobe (d_rstrobe),
      .d_ack     (d_ack),
      .dwrite    (dwrite),
      .qdin      (qdin),
      .qdout     (qdout),
      .qoe       (qoe),
      .cs        (cs),
      .dread     (dread)
`ifdef QSPI_MC_CFG_EN
      ,
      .cfg_write (cfg_write),
      .cfg_addr  (cfg_addr),
      .cfg_data  (cfg_data)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents data, strobes, acks or a cs assertion.
   always @(negedge clk) begin
      if (qoe == 4'hF) begin
         if (exp_q.size() == 0) check("qoe_nothing_expected", qoe, 0);
         else check("qdout", qdout, exp_q.pop_front());
      end else if (qoe != 4'h0) begin
         check("qoe_value", qoe, 0);
      end

      if (i_wstrobe) begin
         if (exp_i.size() == 0) check("i_wstrobe_unexpected", i_wstrobe, 0);
         else check("i_dread", dread, exp_i.pop_front());
      end
      if (d_wstrobe) begin
         if (exp_d.size() == 0) check("d_wstrobe_unexpected", d_wstrobe, 0);
         else check("d_dread", dread, exp_d.pop_front());
      end

      if (i_ack || d_ack) begin
         if (exp_ack.size() == 0) check("ack_unexpected", {i_ack, d_ack}, 0);
         else begin
            a_pop = exp_ack.pop_front();
            check("ack_source", {i_ack, d_ack}, (a_pop.who != 0) ? 1 : 2);
            check("ack_cycle", cyc, a_pop.cyc);
         end
      end

      if (cs != 2'b11) begin
         if (!prev_low) begin
            n_fall++;
            if (exp_cs.size() == 0) check("cs_unexpected", cs, 3);
            else check("cs_select", cs, exp_cs.pop_front());
            if (n_fall == gap_idx) check("cs_high_gap", cyc - last_low - 1, 2);
            cur_cs = cs;
         end else if (cs != cur_cs) begin
            check("cs_stable", cs, cur_cs);
         end
         last_low = cyc;
      end
      prev_low = (cs != 2'b11);

      if (d_rstrobe) rs_cnt++;
      widx = rs_cnt - w_base;
      dwrite = (widx >= 0 && widx < 8) ? w_line[31-4*widx -: 4] : 4'h0;
      qdin = qdin_map.exists(cyc) ? qdin_map[cyc] : 4'(cyc);
   end

   // Issue a request at the current negedge; the DUT grants it dly cycles later.
   task automatic issue(input bit is_d, input bit wr, input logic [19:0] tag, input logic cs_idx,
                        input logic [31:0] hdr, input logic [31:0] line, input int dly,
                        input int dmy, input int n_rd, input bit with_ack);
      int   g;
      ack_t a;
      g = cyc + dly;
      for (int n = 0; n < 8; n++) exp_q.push_back(hdr[31-4*n -: 4]);
      exp_cs.push_back(cs_idx ? 2'b01 : 2'b10);
      if (wr) begin
         w_line = line;
         w_base = rs_cnt;
         for (int n = 0; n < 8; n++) exp_q.push_back(line[31-4*n -: 4]);
      end else begin
         for (int n = 0; n < 8; n++) begin
            qdin_map[g + 9 + dmy + n] = line[31-4*n -: 4];
            if (n < n_rd) begin
               if (is_d) exp_d.push_back(line[31-4*n -: 4]);
               else exp_i.push_back(line[31-4*n -: 4]);
            end
         end
      end
      if (with_ack) begin
         a.who = is_d ? 1 : 0;
         a.cyc = g + 17 + (wr ? 0 : dmy);
         exp_ack.push_back(a);
      end
      if (is_d) begin
         d_req = 1'b1; d_write = wr; d_tag = tag; d_cs = cs_idx;
      end else begin
         i_req = 1'b1; i_tag = tag; i_cs = cs_idx;
      end
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while ((exp_ack.size() + exp_q.size() + exp_i.size() + exp_d.size()) != 0 && k < budget) begin
         @(negedge clk);
         k++;
         if (i_ack) i_req = 1'b0;
         if (d_ack) d_req = 1'b0;
      end
      if (k >= budget) check("timeout_pending", exp_ack.size() + exp_q.size() + exp_i.size() + exp_d.size(), 0);
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_cs"}, cs, 3);
      check({tag, "_qoe"}, qoe, 0);
      check({tag, "_qdout"}, qdout, 0);
      check({tag, "_dread"}, dread, 0);
      check({tag, "_strobes"}, {i_wstrobe, d_wstrobe, d_rstrobe}, 0);
      check({tag, "_acks"}, {i_ack, d_ack}, 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // icache read of address 0x000100 with four dummy cycles
      issue(1'b0, 1'b0, 20'h00040, 1'b0, 32'hEB000100, 32'hA53C71E9, 0, 4, 8, 1'b1);
      wait_done(100);

      // dcache write of address 0x000040, nibbles 1..8
      issue(1'b1, 1'b1, 20'h00010, 1'b0, 32'h38000040, 32'h12345678, 0, 0, 0, 1'b1);
      wait_done(100);
      check("d_rstrobe_count", rs_cnt - w_base, 8);

      // simultaneous requests straight out of reset; second one waits for the first ack
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      gap_idx = n_fall + 2;
      issue(1'b1, 1'b0, 20'hFFFFF, 1'b0, 32'hEB3FFFFC, 32'h0F1E2D3C, 0, 4, 8, 1'b1);
      issue(1'b0, 1'b0, 20'h48D17, 1'b1, 32'hEB12345C, 32'h5A69784B, 22, 4, 8, 1'b1);
      wait_done(150);

      // reset during the third DATA cycle abandons the transfer without ack
      issue(1'b0, 1'b0, 20'h00001, 1'b0, 32'hEB000004, 32'h9D5A3C71, 0, 4, 2, 1'b0);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      i_req = 1'b0;
      @(negedge clk);
      check_quiet("abort");
      check("abort_leftover", exp_q.size() + exp_i.size(), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // dcache write on chip select 1 after the abort
      issue(1'b1, 1'b1, 20'h2AAAA, 1'b1, 32'h380AAAA8, 32'hFEDCBA98, 0, 0, 0, 1'b1);
      wait_done(100);
      check("d_rstrobe_count_cs1", rs_cnt - w_base, 8);

`ifdef QSPI_MC_CFG_EN
      cfg_write = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h00;
      @(negedge clk);
      cfg_write = 1'b0;
      @(negedge clk);
      issue(1'b0, 1'b0, 20'h00040, 1'b0, 32'hEB000100, 32'h13579BDF, 0, 0, 8, 1'b1);
      repeat (3) @(negedge clk);
      cfg_write = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h05;
      @(negedge clk);
      cfg_write = 1'b0;
      wait_done(100);
      issue(1'b0, 1'b0, 20'h00041, 1'b1, 32'hEB000104, 32'h2468ACE0, 0, 0, 8, 1'b1);
      wait_done(100);
`endif

      repeat (3) @(negedge clk);
      check("queues_drained", exp_q.size() + exp_i.size() + exp_d.size() + exp_ack.size() + exp_cs.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
